cluster_load_ctrl: RTL and testbench
====================================

// Module: cluster_load_ctrl
// PURPOSE
//  Parametrised sequencer for one GLB/router/PE cluster slice. Performs the load->compute->writeback
//  schedule: streams KERNEL_SIZE^2 weights and ACT_SIZE^2 activations from GLB through the WEST router ports,
//  runs NUM_ITER PE_cluster passes and writes X_DIM psums per pass into the psum GLB.
//  Replaces hand-driven sequencing; supports abort, compute_done edge detection and cycle counting.
// PARAMETERS
//  DATA_WIDTH   16   data word width
//  ADDR_WIDTH   10   GLB address width
//  KERNEL_SIZE  3    filter side; weight words = KERNEL_SIZE^2
//  ACT_SIZE     5    activation side; act words = ACT_SIZE^2
//  X_DIM        3    PE columns = psums per pass
//  NUM_ITER     3    compute passes (default ACT_SIZE-KERNEL_SIZE+1)
//  W_BASE       0    weight GLB read base;  A_BASE 0 act GLB read base;  PSUM_BASE 500 psum GLB write base
//  GAP_CYCLES   4    idle cycles between passes (>=1)
// PORTS
//  clk              in   1                 clock, rising edge
//  reset            in   1                 asynchronous, active-low reset
//  go               in   1                 start schedule (sampled in IDLE only)
//  abort            in   1                 synchronous abort
//  busy             out  1                 high from state after IDLE until return to IDLE
//  done             out  1                 1-cycle pulse, schedule complete
//  read_req_wght / r_addr_wght  out 1 / ADDR_WIDTH   weight GLB read
//  read_req_iact / r_addr_iact  out 1 / ADDR_WIDTH   act GLB read
//  router_mode_wght / router_mode_iact  out 4    0=ALL (idle), 3=WEST (stream)
//  west_enable_i_wght / west_enable_i_iact  out 1   router west-input valid
//  load_en_wght / load_en_act  out 1              PE_cluster load strobes
//  pe_start         out  1                 PE_cluster start pulse
//  pe_compute_done  in   1                 PE_cluster completion (level)
//  pe_out           in   X_DIM*DATA_WIDTH  column j at [j*DATA_WIDTH +: DATA_WIDTH]
//  write_en_psum / w_addr_psum / w_data_psum  out 1 / ADDR_WIDTH / DATA_WIDTH   psum GLB write
//  cycles           out  32                cycles from go acceptance to done; held until next go
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE; all outputs 0, incl. cycles, counters, addresses.
//  GLB read latency = 1 cycle; router WEST path combinational.
//  States: IDLE -> W_PRIME -> W_STREAM -> A_PRIME -> A_STREAM -> START -> WAIT -> DRAIN -> (GAP -> START | DONE) -> IDLE.
//  IDLE: go=1 -> W_PRIME, cycles cleared to 0, iter=0. go ignored in every other state.
//  W_PRIME (1 cyc): read_req_wght=1, r_addr_wght=W_BASE.
//  W_STREAM (KERNEL_SIZE^2 cyc, index i=0..KK-1): router_mode_wght=3, west_enable_i_wght=1;
//   load_en_wght=1 only at i=0; r_addr_wght=W_BASE+i+1, read_req_wght=1 for i<KK-1, 0 at i=KK-1.
//  A_PRIME/A_STREAM: identical pattern on iact signals, ACT_SIZE^2 words, base A_BASE.
//  Leaving a stream state: mode back to 0, enables 0, next cycle.
//  START (1 cyc): pe_start=1; arms done detector.
//  WAIT: exit only on pe_compute_done 0->1 edge seen after START (stale high level ignored).
//  DRAIN (X_DIM cyc, j=0..X_DIM-1): write_en_psum=1, w_addr_psum=PSUM_BASE+iter*X_DIM+j,
//   w_data_psum=pe_out column X_DIM-1-j (captured on done-edge cycle; stable through DRAIN).
//  After DRAIN: iter<NUM_ITER-1 -> iter++, GAP for GAP_CYCLES then START; else DONE.
//  DONE (1 cyc): done=1, then IDLE. busy=0 in IDLE only.
//  cycles increments each cycle busy=1 (including DONE); saturates at 2^32-1.
//  abort=1 in any non-IDLE state: next cycle IDLE, all strobes/enables 0, no done, no further psum writes;
//   cycles holds value. abort has priority over every transition; abort in IDLE no effect.
//  Address arithmetic modulo 2^ADDR_WIDTH (wraps, no error).
//  Reset asserted mid-schedule: immediate async return to reset state; no partial writes after.
// TESTING
//  T1 defaults, go pulse, pe_compute_done rises 20 cyc after each pe_start -> 9 wght reads addr 0..8,
//     25 act reads addr 0..24, 9 psum writes addr 500..508, single done pulse.
//  T2 load_en_wght/load_en_act each high exactly 1 cycle, coincident with first stream cycle; west_enable high 9/25 cycles.
//  T3 hold pe_compute_done high from pass 1 into pass 2 -> ctrl stays in WAIT until a fresh 0->1 edge.
//  T4 pe_out={30,20,10} (col2..col0) in pass 0 -> writes 500=30? no: w_data order col2,col1,col0 = 30,20,10.
//  T5 abort during DRAIN pass 1 (after addr 504) -> no writes >=505, no done, busy=0 next cycle; go then restarts cleanly.
//  T6 reset low mid-A_STREAM -> all outputs 0 immediately; KERNEL_SIZE=2, ACT_SIZE=4, X_DIM=2 rerun -> 4/16 reads, 6 writes.

Source files
------------

// File: rtl/cluster_load_ctrl.sv
// Load -> compute -> writeback sequencer for one GLB/router/PE cluster slice.
// Every output is registered from the next-state decode, so each output
// changes in the same cycle as the state it belongs to.
module cluster_load_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned ACT_SIZE    = 5,
  parameter int unsigned X_DIM       = 3,
  parameter int unsigned NUM_ITER    = ACT_SIZE - KERNEL_SIZE + 1,
  parameter int unsigned W_BASE      = 0,
  parameter int unsigned A_BASE      = 0,
  parameter int unsigned PSUM_BASE   = 500,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          read_req_wght,
  output logic [ADDR_WIDTH-1:0]         r_addr_wght,
  output logic                          read_req_iact,
  output logic [ADDR_WIDTH-1:0]         r_addr_iact,
  output logic [3:0]                    router_mode_wght,
  output logic [3:0]                    router_mode_iact,
  output logic                          west_enable_i_wght,
  output logic                          west_enable_i_iact,
  output logic                          load_en_wght,
  output logic                          load_en_act,
  output logic                          pe_start,
  input  logic                          pe_compute_done,
  input  logic [X_DIM*DATA_WIDTH-1:0]   pe_out,
  output logic                          write_en_psum,
  output logic [ADDR_WIDTH-1:0]         w_addr_psum,
  output logic [DATA_WIDTH-1:0]         w_data_psum,
  output logic [31:0]                   cycles
);

  localparam int unsigned KK      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned AA      = ACT_SIZE * ACT_SIZE;
  localparam int unsigned MAX_KA  = (KK > AA) ? KK : AA;
  localparam int unsigned MAX_XG  = (X_DIM > GAP_CYCLES) ? X_DIM : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_KA > MAX_XG) ? MAX_KA : MAX_XG;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned ITER_W  = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int unsigned COL_W   = (X_DIM > 1) ? $clog2(X_DIM) : 1;
  localparam int unsigned PE_W    = X_DIM * DATA_WIDTH;
  localparam logic [3:0]  MODE_WEST = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_W_PRIME, S_W_STREAM, S_A_PRIME, S_A_STREAM,
    S_START, S_WAIT, S_DRAIN, S_GAP, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    idx, idx_n;
  logic [ITER_W-1:0]   iter, iter_n;
  logic                compute_done_q;
  logic [PE_W-1:0]     psum_buf;
  logic [PE_W-1:0]     buf_n_c;
  logic                done_edge_c;
  logic [DATA_WIDTH-1:0] drain_cols [X_DIM];

  logic                  busy_d, done_d, rrw_d, rri_d, west_w_d, west_a_d;
  logic                  load_w_d, load_a_d, pe_start_d, we_d;
  logic [3:0]            mode_w_d, mode_a_d;
  logic [ADDR_WIDTH-1:0] raw_d, rai_d, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Rising edge of pe_compute_done; only ever consulted in WAIT, which is entered from START
  assign done_edge_c = pe_compute_done & ~compute_done_q;
  assign buf_n_c     = (state == S_WAIT && done_edge_c) ? pe_out : psum_buf;

  // Drain order is highest column first
  for (genvar j = 0; j < X_DIM; j++) begin : g_cols
    assign drain_cols[j] = buf_n_c[(X_DIM-1-j)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state / counters, then output decode from the next state
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    iter_n     = iter;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rrw_d      = 1'b0;
    rri_d      = 1'b0;
    raw_d      = '0;
    rai_d      = '0;
    mode_w_d   = '0;
    mode_a_d   = '0;
    west_w_d   = 1'b0;
    west_a_d   = 1'b0;
    load_w_d   = 1'b0;
    load_a_d   = 1'b0;
    pe_start_d = 1'b0;
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;

    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      idx_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: if (go) begin
          state_n = S_W_PRIME;
          idx_n   = '0;
          iter_n  = '0;
        end
        S_W_PRIME: begin state_n = S_W_STREAM; idx_n = '0; end
        S_W_STREAM: begin
          if (32'(idx) == KK - 1) begin state_n = S_A_PRIME; idx_n = '0; end
          else idx_n = idx + CNT_W'(1);
        end
        S_A_PRIME: begin state_n = S_A_STREAM; idx_n = '0; end
        S_A_STREAM: begin
          if (32'(idx) == AA - 1) begin state_n = S_START; idx_n = '0; end
          else idx_n = idx + CNT_W'(1);
        end
        S_START: state_n = S_WAIT;
        S_WAIT: if (done_edge_c) begin state_n = S_DRAIN; idx_n = '0; end
        S_DRAIN: begin
          if (32'(idx) == X_DIM - 1) begin
            idx_n = '0;
            if (32'(iter) < NUM_ITER - 1) begin
              iter_n  = iter + ITER_W'(1);
              state_n = S_GAP;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            idx_n = idx + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (32'(idx) == GAP_CYCLES - 1) begin state_n = S_START; idx_n = '0; end
          else idx_n = idx + CNT_W'(1);
        end
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    busy_d = (state_n != S_IDLE);
    unique case (state_n)
      S_W_PRIME: begin rrw_d = 1'b1; raw_d = ADDR_WIDTH'(W_BASE); end
      S_W_STREAM: begin
        mode_w_d = MODE_WEST;
        west_w_d = 1'b1;
        load_w_d = (idx_n == '0);
        rrw_d    = (32'(idx_n) != KK - 1);
        raw_d    = ADDR_WIDTH'(W_BASE + 32'(idx_n) + 32'd1);
      end
      S_A_PRIME: begin rri_d = 1'b1; rai_d = ADDR_WIDTH'(A_BASE); end
      S_A_STREAM: begin
        mode_a_d = MODE_WEST;
        west_a_d = 1'b1;
        load_a_d = (idx_n == '0);
        rri_d    = (32'(idx_n) != AA - 1);
        rai_d    = ADDR_WIDTH'(A_BASE + 32'(idx_n) + 32'd1);
      end
      S_START: pe_start_d = 1'b1;
      S_DRAIN: begin
        we_d    = 1'b1;
        waddr_d = ADDR_WIDTH'(PSUM_BASE + 32'(iter_n) * X_DIM + 32'(idx_n));
        wdata_d = drain_cols[COL_W'(idx_n)];
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters, capture buffer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      idx                <= '0;
      iter               <= '0;
      compute_done_q     <= 1'b0;
      psum_buf           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      read_req_wght      <= 1'b0;
      r_addr_wght        <= '0;
      read_req_iact      <= 1'b0;
      r_addr_iact        <= '0;
      router_mode_wght   <= '0;
      router_mode_iact   <= '0;
      west_enable_i_wght <= 1'b0;
      west_enable_i_iact <= 1'b0;
      load_en_wght       <= 1'b0;
      load_en_act        <= 1'b0;
      pe_start           <= 1'b0;
      write_en_psum      <= 1'b0;
      w_addr_psum        <= '0;
      w_data_psum        <= '0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      iter               <= iter_n;
      compute_done_q     <= pe_compute_done;
      psum_buf           <= buf_n_c;
      busy               <= busy_d;
      done               <= done_d;
      read_req_wght      <= rrw_d;
      r_addr_wght        <= raw_d;
      read_req_iact      <= rri_d;
      r_addr_iact        <= rai_d;
      router_mode_wght   <= mode_w_d;
      router_mode_iact   <= mode_a_d;
      west_enable_i_wght <= west_w_d;
      west_enable_i_iact <= west_a_d;
      load_en_wght       <= load_w_d;
      load_en_act        <= load_a_d;
      pe_start           <= pe_start_d;
      write_en_psum      <= we_d;
      w_addr_psum        <= waddr_d;
      w_data_psum        <= wdata_d;
    end
  end

  // Busy-cycle counter: cleared on go, saturating, frozen by abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (state == S_IDLE) begin
      if (go) cycles <= '0;
    end else if (!abort && cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Directed bench for cluster_load_ctrl: default slice plus a small
// KERNEL_SIZE=2 / ACT_SIZE=4 / X_DIM=2 instance.
module tb_cluster_load_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, go, abort, pe_compute_done;
  logic [3*DW-1:0] pe_out;
  logic busy, done, read_req_wght, read_req_iact, west_enable_i_wght, west_enable_i_iact;
  logic load_en_wght, load_en_act, pe_start, write_en_psum;
  logic [AW-1:0] r_addr_wght, r_addr_iact, w_addr_psum;
  logic [3:0] router_mode_wght, router_mode_iact;
  logic [DW-1:0] w_data_psum;
  logic [31:0] cycles;

  logic go_s, pe_done_s;
  logic [2*DW-1:0] pe_out_s;
  logic busy_s, done_s, rrw_s, rri_s, west_w_s, west_a_s, load_w_s, load_a_s, pe_start_s, we_s;
  logic [AW-1:0] raw_s, rai_s, waddr_s;
  logic [3:0] mode_w_s, mode_a_s;
  logic [DW-1:0] wdata_s;
  logic [31:0] cycles_s;

  cluster_load_ctrl u_dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .busy(busy), .done(done),
    .read_req_wght(read_req_wght), .r_addr_wght(r_addr_wght),
    .read_req_iact(read_req_iact), .r_addr_iact(r_addr_iact),
    .router_mode_wght(router_mode_wght), .router_mode_iact(router_mode_iact),
    .west_enable_i_wght(west_enable_i_wght), .west_enable_i_iact(west_enable_i_iact),
    .load_en_wght(load_en_wght), .load_en_act(load_en_act), .pe_start(pe_start),
    .pe_compute_done(pe_compute_done), .pe_out(pe_out),
    .write_en_psum(write_en_psum), .w_addr_psum(w_addr_psum), .w_data_psum(w_data_psum),
    .cycles(cycles)
  );

  cluster_load_ctrl #(.KERNEL_SIZE(2), .ACT_SIZE(4), .X_DIM(2)) u_dut_small (
    .clk(clk), .reset(reset), .go(go_s), .abort(1'b0), .busy(busy_s), .done(done_s),
    .read_req_wght(rrw_s), .r_addr_wght(raw_s),
    .read_req_iact(rri_s), .r_addr_iact(rai_s),
    .router_mode_wght(mode_w_s), .router_mode_iact(mode_a_s),
    .west_enable_i_wght(west_w_s), .west_enable_i_iact(west_a_s),
    .load_en_wght(load_w_s), .load_en_act(load_a_s), .pe_start(pe_start_s),
    .pe_compute_done(pe_done_s), .pe_out(pe_out_s),
    .write_en_psum(we_s), .w_addr_psum(waddr_s), .w_data_psum(wdata_s),
    .cycles(cycles_s)
  );

  int errors = 0;
  int checks = 0;

  // Single comparison point for every check in the bench
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Per-run observation counters for the default instance (cleared when go is accepted)
  int w_rd = 0, w_bad = 0, a_rd = 0, a_bad = 0, w_west = 0, a_west = 0;
  int w_load = 0, a_load = 0, w_load_ok = 0, a_load_ok = 0;
  int wr_cnt = 0, done_cnt = 0, ps_cnt = 0;
  logic [AW-1:0] wr_addr [16];
  logic [DW-1:0] wr_data [16];
  logic west_w_q = 1'b0, west_a_q = 1'b0;

  always @(negedge clk) begin
    if (go && !busy) begin
      w_rd = 0; w_bad = 0; a_rd = 0; a_bad = 0; w_west = 0; a_west = 0;
      w_load = 0; a_load = 0; w_load_ok = 0; a_load_ok = 0;
      wr_cnt = 0; done_cnt = 0; ps_cnt = 0;
    end else begin
      if (read_req_wght) begin
        if (r_addr_wght != AW'(w_rd)) w_bad++;
        w_rd++;
      end
      if (read_req_iact) begin
        if (r_addr_iact != AW'(a_rd)) a_bad++;
        a_rd++;
      end
      if (west_enable_i_wght && router_mode_wght == 4'd3) w_west++;
      if (west_enable_i_iact && router_mode_iact == 4'd3) a_west++;
      if (load_en_wght) w_load++;
      if (load_en_act) a_load++;
      if (load_en_wght && west_enable_i_wght && !west_w_q) w_load_ok++;
      if (load_en_act && west_enable_i_iact && !west_a_q) a_load_ok++;
      if (write_en_psum) begin
        if (wr_cnt < 16) begin
          wr_addr[wr_cnt] = w_addr_psum;
          wr_data[wr_cnt] = w_data_psum;
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (pe_start) ps_cnt++;
    end
    west_w_q = west_enable_i_wght;
    west_a_q = west_enable_i_iact;
  end

  // Counters for the small instance
  int s_w_rd = 0, s_a_rd = 0, s_rd_bad = 0, s_wr = 0, s_wr_bad = 0, s_dat_bad = 0, s_done = 0;
  always @(negedge clk) begin
    if (go_s && !busy_s) begin
      s_w_rd = 0; s_a_rd = 0; s_rd_bad = 0; s_wr = 0; s_wr_bad = 0; s_dat_bad = 0; s_done = 0;
    end else begin
      if (rrw_s) begin if (raw_s != AW'(s_w_rd)) s_rd_bad++; s_w_rd++; end
      if (rri_s) begin if (rai_s != AW'(s_a_rd)) s_rd_bad++; s_a_rd++; end
      if (we_s) begin
        if (waddr_s != AW'(500 + s_wr)) s_wr_bad++;
        if (wdata_s != ((s_wr % 2 == 0) ? 16'd7 : 16'd3)) s_dat_bad++;
        s_wr++;
      end
      if (done_s) s_done++;
    end
  end

  // pass p, column c carries 10*(c+1) + 100*p
  function automatic logic [3*DW-1:0] pe_vec(input int p);
    return {DW'(30 + 100 * p), DW'(20 + 100 * p), DW'(10 + 100 * p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    tick(); go = 1'b1;
    tick(); go = 1'b0;
  endtask

  task automatic wait_pe_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (pe_start) ok = 1'b1;
    end
    if (!ok) chk("pe_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // One compute pass: completion rises in the 19th cycle after pe_start, so WAIT lasts 19 cycles
  task automatic do_pass(input int p, input bit hold);
    bit ok;
    pe_out = pe_vec(p);
    wait_pe_start(ok);
    repeat (19) tick();
    pe_compute_done = 1'b1;
    tick();
    if (!hold) pe_compute_done = 1'b0;
  endtask

  // Full default run: 36 load cycles + 3*(1+19+3) + 2*4 gap + 1 done = 114
  task automatic full_run_checks(input string t);
    chk({t, "_w_reads"}, 32'(w_rd), 32'd9);
    chk({t, "_w_addr_seq"}, 32'(w_bad), 32'd0);
    chk({t, "_a_reads"}, 32'(a_rd), 32'd25);
    chk({t, "_a_addr_seq"}, 32'(a_bad), 32'd0);
    chk({t, "_writes"}, 32'(wr_cnt), 32'd9);
    chk({t, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({t, "_cycles"}, cycles, 32'd114);
    chk({t, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [31:0] c0;
    reset = 1'b0; go = 1'b0; abort = 1'b0; pe_compute_done = 1'b0; pe_out = '0;
    go_s = 1'b0; pe_done_s = 1'b0; pe_out_s = {16'd7, 16'd3};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_outs", {write_en_psum, read_req_wght, pe_start, router_mode_wght, r_addr_wght, w_addr_psum}, 32'd0);
    tick(); reset = 1'b1;

    // T1 / T2 / T4: nominal schedule
    start_run();
    for (int p = 0; p < 3; p++) do_pass(p, 1'b0);
    wait_done();
    @(negedge clk);
    full_run_checks("t1");
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_pe_starts", 32'(ps_cnt), 32'd3);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_waddr%0d", i), 32'(wr_addr[i]), 32'(500 + i));
      chk($sformatf("t4_wdata%0d", i), 32'(wr_data[i]), 32'(10 * (3 - i % 3) + 100 * (i / 3)));
    end
    chk("t2_load_w", 32'(w_load), 32'd1);
    chk("t2_load_w_first", 32'(w_load_ok), 32'd1);
    chk("t2_load_a", 32'(a_load), 32'd1);
    chk("t2_load_a_first", 32'(a_load_ok), 32'd1);
    chk("t2_west_w", 32'(w_west), 32'd9);
    chk("t2_west_a", 32'(a_west), 32'd25);

    // T3: completion held high from pass 1 into pass 2
    start_run();
    do_pass(0, 1'b0);
    do_pass(1, 1'b1);
    pe_out = pe_vec(2);
    wait_pe_start(ok);
    repeat (10) tick();
    @(negedge clk);
    chk("t3_stale_no_write", 32'(write_en_psum), 32'd0);
    chk("t3_stale_writes", 32'(wr_cnt), 32'd6);
    chk("t3_stale_busy", 32'(busy), 32'd1);
    tick(); pe_compute_done = 1'b0;
    tick(); pe_compute_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_fresh_we", 32'(write_en_psum), 32'd1);
    chk("t3_fresh_addr", 32'(w_addr_psum), 32'd506);
    chk("t3_fresh_data", 32'(w_data_psum), 32'd230);
    tick(); pe_compute_done = 1'b0;
    wait_done();
    @(negedge clk);
    chk("t3_writes", 32'(wr_cnt), 32'd9);
    chk("t3_done_pulses", 32'(done_cnt), 32'd1);

    // T5: abort in pass-1 drain right after the 504 write is presented
    start_run();
    do_pass(0, 1'b0);
    do_pass(1, 1'b0);
    tick(); abort = 1'b1;
    @(negedge clk);
    chk("t5_at_504_we", 32'(write_en_psum), 32'd1);
    chk("t5_at_504_addr", 32'(w_addr_psum), 32'd504);
    tick(); abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_after", 32'(busy), 32'd0);
    chk("t5_we_after", 32'(write_en_psum), 32'd0);
    c0 = cycles;
    repeat (5) @(negedge clk);
    chk("t5_cycles_hold", cycles, c0);
    chk("t5_writes", 32'(wr_cnt), 32'd5);
    chk("t5_last_addr", 32'(wr_addr[4]), 32'd504);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    start_run();
    for (int p = 0; p < 3; p++) do_pass(p, 1'b0);
    wait_done();
    @(negedge clk);
    full_run_checks("t5_restart");
    chk("t5_restart_last_addr", 32'(wr_addr[8]), 32'd508);

    // T6: async reset in the middle of the activation stream
    start_run();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (read_req_iact && r_addr_iact == AW'(10)) ok = 1'b1;
    end
    chk("t6_reach_astream", 32'(ok), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_iact_outs", {read_req_iact, west_enable_i_iact, load_en_act, router_mode_iact, r_addr_iact}, 32'd0);
    chk("t6_cycles", cycles, 32'd0);
    tick(); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_writes", 32'(wr_cnt), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    // T6 rerun on the small slice: 4 weight reads, 16 act reads, 6 psum writes
    tick(); go_s = 1'b1;
    tick(); go_s = 1'b0;
    for (int p = 0; p < 3; p++) begin
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        if (pe_start_s) ok = 1'b1;
      end
      chk($sformatf("t6s_pe_start%0d", p), 32'(ok), 32'd1);
      repeat (5) tick();
      pe_done_s = 1'b1;
      tick();
      pe_done_s = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (done_s) ok = 1'b1;
    end
    chk("t6s_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    chk("t6s_w_reads", 32'(s_w_rd), 32'd4);
    chk("t6s_a_reads", 32'(s_a_rd), 32'd16);
    chk("t6s_rd_addr", 32'(s_rd_bad), 32'd0);
    chk("t6s_writes", 32'(s_wr), 32'd6);
    chk("t6s_wr_addr", 32'(s_wr_bad), 32'd0);
    chk("t6s_wr_data", 32'(s_dat_bad), 32'd0);
    chk("t6s_done_pulses", 32'(s_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
